axis_packet_arbiter: RTL and testbench

- Shares one downstream AXI-Stream (tdata/tvalid/tready/tlast) between NUM_REQ upstream packet sources.
- Round-robin arbitration at packet granularity: once granted, a source owns the output until its tlast beat completes.
- Used in front of shared consumers (UART TX, debug/trace sink, memory-write port), so packets from different sources never interleave.

---
 rtl/axis_packet_arbiter.sv | 169 ++++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - packet-granular round-robin arbiter for NUM_REQ AXI-Stream sources
// Optional registered output (2-entry skid) when AXIS_ARB_OUT_REG_EN is defined.
module axis_packet_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  input  logic [NUM_REQ-1:0]            s_tlast,
  output logic [NUM_REQ-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [$clog2(NUM_REQ)-1:0]    grant,
  output logic                          grant_valid
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q;
  logic [GW-1:0]         grant_q;
  logic [GW-1:0]         rr_ptr_q;
  logic                  grant_valid_q;

  logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];
  logic                  busy;
  logic                  own_tvalid;
  logic                  own_tlast;
  logic [DATA_WIDTH-1:0] own_tdata;
  logic [GW-1:0]         g_next;
  logic [GW-1:0]         search_ptr;
  logic [NUM_REQ-1:0]    req;
  logic [GW:0]           pos;
  logic                  arb_found;
  logic [GW-1:0]         arb_idx;
  logic                  pkt_end;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign busy       = (state_q == BUSY);
  assign own_tvalid = s_tvalid[grant_q];
  assign own_tlast  = s_tlast[grant_q];
  assign own_tdata  = lane_data[grant_q];
  assign g_next     = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign search_ptr = busy ? g_next : rr_ptr_q;

  // The finishing owner is masked so it goes to the back of the round-robin order.
  always_comb begin
    req = s_tvalid;
    if (busy) req[grant_q] = 1'b0;
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    pos       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, search_ptr} + (GW+1)'(k);
      if (pos >= (GW+1)'(NUM_REQ)) pos = pos - (GW+1)'(NUM_REQ);
      if (req[pos[GW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = pos[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            state_q       <= BUSY;
            grant_q       <= arb_idx;
            grant_valid_q <= 1'b1;
          end
        end
        BUSY: begin
          if (pkt_end) begin
            rr_ptr_q <= g_next;
            if (arb_found) begin
              grant_q <= arb_idx;
            end else begin
              state_q       <= IDLE;
              grant_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;

`ifdef AXIS_ARB_OUT_REG_EN
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  skid_valid_q;
  logic                  skid_last_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic                  up_ready;
  logic                  up_hs;

  // Upstream readiness depends only on skid occupancy, never on m_tready.
  assign up_ready = busy & ~skid_valid_q;
  assign up_hs    = up_ready & own_tvalid;
  assign pkt_end  = up_hs & own_tlast;

  always_comb begin
    s_tready = '0;
    if (busy) s_tready[grant_q] = up_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else if (m_tready || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_last_q   <= skid_last_q;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= up_hs;
        out_last_q  <= own_tlast;
        out_data_q  <= own_tdata;
      end
    end else if (up_hs) begin
      skid_valid_q <= 1'b1;
      skid_last_q  <= own_tlast;
      skid_data_q  <= own_tdata;
    end
  end

  assign m_tvalid = out_valid_q;
  assign m_tlast  = out_last_q;
  assign m_tdata  = out_data_q;
`else
  assign pkt_end = busy & own_tvalid & m_tready & own_tlast;

  always_comb begin
    s_tready = '0;
    if (busy) s_tready[grant_q] = m_tready;
  end

  assign m_tvalid = busy & own_tvalid;
  assign m_tlast  = busy & own_tlast;
  assign m_tdata  = busy ? own_tdata : '0;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - directed bench for axis_packet_arbiter
module tb_axis_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
`ifdef AXIS_ARB_OUT_REG_EN
  localparam int FIRST_LAT = 3;
  localparam int TOTAL_CYC = 10;
`else
  localparam int FIRST_LAT = 2;
  localparam int TOTAL_CYC = 9;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [1:0]        grant;
  logic              grant_valid;

  logic [7:0]  mem   [N][8];
  logic        lastm [N][8];
  int          len   [N];
  int          ptr   [N];
  bit          en    [N];
  logic [15:0] log_q [$];
  logic [N-1:0] hs;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          cyc;
  int          first;
  int          stalls;
  logic        tog;

  axis_packet_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [7:0] data, input logic last);
    check($sformatf("%s_beat%0d", tag, idx),
          (idx < log_q.size()) ? 32'(log_q[idx]) : 32'hDEAD,
          32'({7'd0, last, data}));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && ptr[i] < len[i]) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = mem[i][ptr[i]];
        s_tlast[i]           = lastm[i][ptr[i]];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic load(input int i, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      mem[i][k]   = 8'(base + k);
      lastm[i][k] = (k == n - 1);
    end
    len[i] = n;
    ptr[i] = 0;
    en[i]  = 1'b1;
  endtask

  // One clock: sample handshakes before the edge, advance sources after it.
  task automatic adv();
    #1;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) log_q.push_back({7'd0, m_tlast, m_tdata});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) ptr[i] = ptr[i] + 1;
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    m_tready = 1'b0;
    for (int i = 0; i < N; i++) begin en[i] = 1'b0; len[i] = 0; ptr[i] = 0; end
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    m_tready = 1'b0;
    drive();
    @(negedge clk);
    @(negedge clk);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant",       32'(grant),       32'd0);
    check("rst_m_tvalid",    32'(m_tvalid),    32'd0);
    check("rst_s_tready",    32'(s_tready),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef AXIS_ARB_OUT_REG_EN
    load(2, 8'hA1, 3);
    m_tready = 1'b1;
    drive();
    #1;
    check("s1_bubble_tvalid", 32'(m_tvalid),    32'd0);
    check("s1_bubble_gv",     32'(grant_valid), 32'd0);
    adv();
    check("s1_grant",    32'(grant),       32'd2);
    check("s1_gv",       32'(grant_valid), 32'd1);
    check("s1_tdata0",   32'(m_tdata),     32'hA1);
    check("s1_s_tready", 32'(s_tready),    32'b0100);
    adv();
    adv();
    check("s1_tdata2", 32'(m_tdata), 32'hA3);
    check("s1_tlast2", 32'(m_tlast), 32'd1);
    adv();
    check("s1_gv_end",    32'(grant_valid), 32'd0);
    check("s1_grant_end", 32'(grant),       32'd2);
    check("s1_count",     32'(log_q.size()), 32'd3);
    check_beat("s1", 0, 8'hA1, 1'b0);
    check_beat("s1", 1, 8'hA2, 1'b0);
    check_beat("s1", 2, 8'hA3, 1'b1);
`endif

    // All four sources at once; round-robin from pointer 0, no gaps between packets.
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) load(i, 8'(16 * (i + 1)), 2);
    drive();
    cyc = 0;
    first = 0;
    while (log_q.size() < 8 && cyc < 40) begin
      adv();
      cyc = cyc + 1;
      if (first == 0 && log_q.size() > 0) first = cyc;
    end
    check("s2_first_latency", 32'(first), 32'(FIRST_LAT));
    check("s2_total_cycles",  32'(cyc),   32'(TOTAL_CYC));
    for (int k = 0; k < 8; k++) check_beat("s2", k, 8'(16 * (k / 2 + 1) + k % 2), (k % 2) == 1);

    // Same traffic with the sink stalling for two cycles mid-stream.
    log_q.delete();
    for (int i = 0; i < N; i++) load(i, 8'(16 * (i + 4)), 2);
    drive();
    cyc = 0;
    stalls = 0;
    while (log_q.size() < 8 && cyc < 40) begin
      if (log_q.size() == 3 && stalls < 2) begin
        m_tready = 1'b0;
        stalls = stalls + 1;
      end else begin
        m_tready = 1'b1;
      end
      adv();
      cyc = cyc + 1;
    end
    m_tready = 1'b1;
    adv();
    adv();
    adv();
    check("s2b_count", 32'(log_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) check_beat("s2b", k, 8'(16 * (k / 2 + 4) + k % 2), (k % 2) == 1);

`ifndef AXIS_ARB_OUT_REG_EN
    // Owner 1 pauses mid-packet; source 3 must wait for its tlast.
    log_q.delete();
    load(1, 8'hC0, 4);
    load(3, 8'hD0, 2);
    drive();
    adv();
    adv();
    adv();
    en[1] = 1'b0;
    drive();
    for (int g = 0; g < 3; g++) begin
      #1;
      check($sformatf("s3_gap%0d", g),
            32'({grant, grant_valid, s_tready[3], m_tvalid}),
            32'({2'd1, 1'b1, 1'b0, 1'b0}));
      adv();
    end
    en[1] = 1'b1;
    drive();
    cyc = 0;
    while (log_q.size() < 6 && cyc < 20) begin adv(); cyc = cyc + 1; end
    for (int k = 0; k < 4; k++) check_beat("s3", k, 8'(8'hC0 + k), k == 3);
    check_beat("s3", 4, 8'hD0, 1'b0);
    check_beat("s3", 5, 8'hD1, 1'b1);

    // Sink ready toggles 1,0,1,0 during a 4-beat packet.
    log_q.delete();
    load(0, 8'hE0, 4);
    m_tready = 1'b0;
    drive();
    adv();
    cyc = 1;
    tog = 1'b1;
    while (log_q.size() < 4 && cyc < 20) begin
      m_tready = tog;
      #1;
      check($sformatf("s4_mirror_c%0d", cyc), 32'(s_tready[0]), 32'(tog));
      adv();
      cyc = cyc + 1;
      tog = ~tog;
    end
    m_tready = 1'b1;
    check("s4_total_cycles", 32'(cyc), 32'd8);
    for (int k = 0; k < 4; k++) check_beat("s4", k, 8'(8'hE0 + k), k == 3);

    // Reset lands mid-packet; afterwards a single-beat packet from source 3.
    log_q.delete();
    load(0, 8'hF0, 4);
    drive();
    adv();
    adv();
    adv();
    rst_n = 1'b0;
    #1;
    check("s5_async_m_tvalid", 32'(m_tvalid),    32'd0);
    check("s5_async_s_tready", 32'(s_tready),    32'd0);
    check("s5_async_gv",       32'(grant_valid), 32'd0);
    check("s5_async_grant",    32'(grant),       32'd0);
    en[0] = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    load(3, 8'h5A, 1);
    drive();
    adv();
    check("s5_grant3",   32'(grant),       32'd3);
    check("s5_gv3",      32'(grant_valid), 32'd1);
    check("s5_single",   32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, 1'b1, 8'h5A}));
    adv();
    check("s5_release",  32'(grant_valid), 32'd0);
    check("s5_count",    32'(log_q.size()), 32'd3);
    check_beat("s5", 0, 8'hF0, 1'b0);
    check_beat("s5", 1, 8'hF1, 1'b0);
    check_beat("s5", 2, 8'h5A, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
